// File: rtl/ahb_spi_if.sv
// AHB-Lite slave-side bus bundle for the SPI master.
interface ahb_spi_if;
  logic        HSEL;
  logic        HREADY;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;

  modport master (
    output HSEL, HREADY, HADDR, HWRITE, HSIZE, HTRANS, HWDATA,
    input  HRDATA, HREADYOUT
  );

  modport slave (
    input  HSEL, HREADY, HADDR, HWRITE, HSIZE, HTRANS, HWDATA,
    output HRDATA, HREADYOUT
  );
endinterface

// File: rtl/ahb_spi.sv
// AHB-Lite slave wrapping a byte-oriented mode-0 SPI master with 32 slave selects.
// Registers: CTRL/STAT (0x0), SS (0x4), TXDATA (0x8, write starts a transfer), RXDATA (0xC).
module ahb_spi #(
  parameter int SCLK_DIV = 32
) (
  input  logic        HCLK,
  input  logic        HRESET,
  ahb_spi_if.slave    bus,
  input  logic        SPI_MISO_i,
  output logic        SPI_MOSI_o,
  output logic [31:0] SPI_SS_o,
  output logic        SPI_CLK_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_t;

  localparam logic [15:0] HALF_M1 = 16'(SCLK_DIV / 2 - 1);

  state_t      state_r;
  logic        dphase_r;
  logic        write_r;
  logic [1:0]  addr_r;
  logic [1:0]  nb_r;
  logic [31:0] ss_r;
  logic [31:0] txdata_r;
  logic [31:0] tx_shift_r;
  logic [31:0] rx_r;
  logic [6:0]  rx_byte_r;
  logic [2:0]  count_r;
  logic        tx_done_r;
  logic        mosi_r;
  logic        sclk_r;
  logic [15:0] div_cnt_r;
  logic [5:0]  bits_left_r;

  logic        busy_s;
  logic        half_end_s;
  logic        start_s;
  logic        rd_rx_s;
  logic        byte_done_s;
  logic        finish_s;
  logic [2:0]  nbytes_s;
  logic [31:0] tx_aligned_s;
  logic        unused_ok_s;

  // Left-justify the valid bytes so the shifter always emits from bit 31.
  function automatic logic [31:0] align_tx(input logic [31:0] d, input logic [1:0] nb);
    case (nb)
      2'd0:    return {d[7:0], 24'h00_0000};
      2'd1:    return {d[15:0], 16'h0000};
      2'd2:    return {d[23:0], 8'h00};
      default: return d;
    endcase
  endfunction

  assign unused_ok_s = ^{bus.HSIZE, bus.HADDR[31:4], bus.HADDR[1:0], bus.HTRANS[0]};

  // Decode of bus events and transfer milestones.
  always_comb begin
    busy_s       = (state_r != ST_IDLE);
    half_end_s   = (div_cnt_r == HALF_M1);
    start_s      = dphase_r & write_r & (addr_r == 2'd2) & ~busy_s;
    rd_rx_s      = dphase_r & ~write_r & (addr_r == 2'd3);
    byte_done_s  = (state_r == ST_LOW) & half_end_s & (bits_left_r[2:0] == 3'd1);
    finish_s     = (state_r == ST_HIGH) & half_end_s & (bits_left_r == 6'd1);
    nbytes_s     = {1'b0, nb_r} + 3'd1;
    tx_aligned_s = align_tx(bus.HWDATA, nb_r);
  end

  // Read mux driven from the registered data-phase address.
  always_comb begin
    case (addr_r)
      2'd0:    bus.HRDATA = {24'h00_0000, nb_r, 1'b0, tx_done_r, 2'b00, busy_s, (count_r == 3'd4)};
      2'd1:    bus.HRDATA = ss_r;
      2'd2:    bus.HRDATA = txdata_r;
      default: bus.HRDATA = rx_r;
    endcase
  end

  assign bus.HREADYOUT = 1'b1;
  assign SPI_MOSI_o    = mosi_r;
  assign SPI_CLK_o     = sclk_r;
  assign SPI_SS_o      = ss_r;

  // Address-phase capture and software-writable registers.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dphase_r <= 1'b0;
      write_r  <= 1'b0;
      addr_r   <= 2'd0;
      nb_r     <= 2'd0;
      ss_r     <= 32'hFFFF_FFFF;
      txdata_r <= 32'h0000_0000;
    end else begin
      dphase_r <= bus.HSEL & bus.HTRANS[1] & bus.HREADY;
      if (bus.HSEL & bus.HTRANS[1] & bus.HREADY) begin
        addr_r  <= bus.HADDR[3:2];
        write_r <= bus.HWRITE;
      end
      if (dphase_r & write_r) begin
        case (addr_r)
          2'd0:    nb_r <= bus.HWDATA[7:6];
          2'd1:    ss_r <= bus.HWDATA;
          2'd2:    if (!busy_s) txdata_r <= bus.HWDATA;
          default: ;
        endcase
      end
    end
  end

  // Transfer sequencer: SCLK phases, MOSI shifting, MISO capture and status flags.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_r     <= ST_IDLE;
      tx_shift_r  <= 32'h0000_0000;
      rx_r        <= 32'h0000_0000;
      rx_byte_r   <= 7'h00;
      count_r     <= 3'd0;
      tx_done_r   <= 1'b0;
      mosi_r      <= 1'b0;
      sclk_r      <= 1'b0;
      div_cnt_r   <= 16'd0;
      bits_left_r <= 6'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            state_r     <= ST_LOW;
            mosi_r      <= tx_aligned_s[31];
            tx_shift_r  <= {tx_aligned_s[30:0], 1'b0};
            bits_left_r <= {nbytes_s, 3'b000};
            div_cnt_r   <= 16'd0;
            sclk_r      <= 1'b0;
          end
        end
        ST_LOW: begin
          if (half_end_s) begin
            state_r   <= ST_HIGH;
            sclk_r    <= 1'b1;
            div_cnt_r <= 16'd0;
            rx_byte_r <= {rx_byte_r[5:0], SPI_MISO_i};
          end else begin
            div_cnt_r <= div_cnt_r + 16'd1;
          end
        end
        ST_HIGH: begin
          if (half_end_s) begin
            sclk_r      <= 1'b0;
            div_cnt_r   <= 16'd0;
            bits_left_r <= bits_left_r - 6'd1;
            if (bits_left_r == 6'd1) begin
              state_r <= ST_IDLE;
            end else begin
              state_r    <= ST_LOW;
              mosi_r     <= tx_shift_r[31];
              tx_shift_r <= {tx_shift_r[30:0], 1'b0};
            end
          end else begin
            div_cnt_r <= div_cnt_r + 16'd1;
          end
        end
        default: state_r <= ST_IDLE;
      endcase

      if (byte_done_s) begin
        rx_r <= {rx_r[23:0], rx_byte_r, SPI_MISO_i};
      end

      // A byte landing on the RXDATA read cycle counts as the first byte after the clear.
      if (rd_rx_s) begin
        count_r <= byte_done_s ? 3'd1 : 3'd0;
      end else if (byte_done_s && (count_r != 3'd4)) begin
        count_r <= count_r + 3'd1;
      end

      if (finish_s) begin
        tx_done_r <= 1'b1;
      end else if (start_s | rd_rx_s) begin
        tx_done_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ahb_spi.sv
// Randomized scoreboard bench for ahb_spi: stimulus pushes expectations, a monitor pops and compares.
module tb_ahb_spi;
  localparam int DIV = 8;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        SPI_MISO_i;
  logic        SPI_MOSI_o;
  logic        SPI_CLK_o;
  logic [31:0] SPI_SS_o;

  ahb_spi_if bus();

  ahb_spi #(.SCLK_DIV(DIV)) dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .bus        (bus),
    .SPI_MISO_i (SPI_MISO_i),
    .SPI_MOSI_o (SPI_MOSI_o),
    .SPI_SS_o   (SPI_SS_o),
    .SPI_CLK_o  (SPI_CLK_o)
  );

  always #5 HCLK = ~HCLK;

  // Scoreboard FIFOs: written by stimulus, read by the monitor.
  logic [31:0] rd_exp  [0:1023];
  logic [3:0]  rd_adr  [0:1023];
  int          rd_wr = 0, rd_rd = 0;
  logic [7:0]  mo_exp  [0:1023];
  int          mo_wr = 0, mo_rd = 0;
  logic        miso_mem[0:4095];
  int          mi_wr = 0, mi_rd = 0;
  logic [34:0] pin_exp [0:63];
  int          pin_wr = 0, pin_rd = 0;
  logic        end_req = 1'b0;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          dcyc = 0;
  logic        rd_dphase = 1'b0;
  logic [3:0]  rd_dadr = 4'h0;
  logic        sclk_d = 1'b0;
  logic [7:0]  sh = 8'h00;
  int          bc = 0;

  // Reference model state
  logic [1:0]  m_nb;
  logic [31:0] m_ss, m_tx, m_rx;
  int          m_cnt;
  logic        m_done;

  assign SPI_MISO_i = (mi_rd < mi_wr) ? miso_mem[mi_rd] : 1'b0;

  always @(posedge HCLK) begin
    cyc       <= cyc + 1;
    rd_dphase <= !HRESET && bus.HSEL && bus.HTRANS[1] && bus.HREADY && !bus.HWRITE;
    rd_dadr   <= bus.HADDR[3:0];
  end

  // Monitor: every comparison happens here, half a cycle away from the active edge.
  always @(negedge HCLK) begin
    logic [7:0] b;
    if (HRESET) begin
      bc     <= 0;
      sclk_d <= 1'b0;
      mo_rd  <= mo_wr;
      mi_rd  <= mi_wr;
    end else begin
      if (rd_dphase) begin
        vectors = vectors + 1;
        if (rd_rd == rd_wr) begin
          miscompares = miscompares + 1;
          $display("FAIL unexpected_read @0x%0h: got %h, nothing expected", rd_dadr, bus.HRDATA);
        end else begin
          if (bus.HRDATA !== rd_exp[rd_rd]) begin
            miscompares = miscompares + 1;
            $display("FAIL read@0x%0h: got %h expected %h", rd_adr[rd_rd], bus.HRDATA, rd_exp[rd_rd]);
          end
          rd_rd <= rd_rd + 1;
        end
      end
      if (SPI_CLK_o && !sclk_d) begin
        b = {sh[6:0], SPI_MOSI_o};
        sh <= b;
        mi_rd <= mi_rd + 1;
        if (bc == 7) begin
          bc <= 0;
          vectors = vectors + 1;
          if (mo_rd == mo_wr) begin
            miscompares = miscompares + 1;
            $display("FAIL mosi_byte: got %h, no byte expected", b);
          end else begin
            if (b !== mo_exp[mo_rd]) begin
              miscompares = miscompares + 1;
              $display("FAIL mosi_byte: got %h expected %h", b, mo_exp[mo_rd]);
            end
            mo_rd <= mo_rd + 1;
          end
        end else begin
          bc <= bc + 1;
        end
      end
      sclk_d <= SPI_CLK_o;
      if (pin_rd != pin_wr) begin
        vectors = vectors + 1;
        if (SPI_SS_o !== pin_exp[pin_rd][32:1] || SPI_CLK_o !== pin_exp[pin_rd][0] ||
            bus.HREADYOUT !== 1'b1 ||
            (pin_exp[pin_rd][34] && SPI_MOSI_o !== pin_exp[pin_rd][33])) begin
          miscompares = miscompares + 1;
          $display("FAIL pins: got ss=%h clk=%b mosi=%b rdy=%b expected ss=%h clk=%b mosi=%b rdy=1",
                   SPI_SS_o, SPI_CLK_o, SPI_MOSI_o, bus.HREADYOUT,
                   pin_exp[pin_rd][32:1], pin_exp[pin_rd][0], pin_exp[pin_rd][33]);
        end
        pin_rd <= pin_rd + 1;
      end
      if (end_req) begin
        vectors = vectors + 1;
        if (rd_rd != rd_wr || mo_rd != mo_wr || bc != 0) begin
          miscompares = miscompares + 1;
          $display("FAIL drain: got reads_left=%0d bytes_left=%0d partial_bits=%0d expected 0/0/0",
                   rd_wr - rd_rd, mo_wr - mo_rd, bc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] stat(input logic busy);
    return {24'h00_0000, m_nb, 1'b0, m_done, 2'b00, busy, (m_cnt == 4)};
  endfunction

  task automatic model_reset();
    m_nb = 2'd0; m_ss = 32'hFFFF_FFFF; m_tx = 32'h0; m_rx = 32'h0; m_cnt = 0; m_done = 1'b0;
  endtask

  task automatic xfer(input logic wr, input logic [3:0] a, input logic [31:0] wd, input logic [2:0] sz);
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = wr; bus.HADDR = {28'h0, a}; bus.HSIZE = sz;
    @(posedge HCLK); #1;
    dcyc = cyc;
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWDATA = wd;
    @(posedge HCLK); #1;
  endtask

  task automatic push_rd(input logic [3:0] a, input logic [31:0] e);
    rd_exp[rd_wr] = e; rd_adr[rd_wr] = a; rd_wr = rd_wr + 1;
  endtask

  task automatic rd_chk(input logic [3:0] a, input logic [31:0] e);
    push_rd(a, e);
    xfer(1'b0, a, 32'h0, 3'b010);
    if (a == 4'hC) begin m_done = 1'b0; m_cnt = 0; end
  endtask

  // Two back-to-back reads of the same register in consecutive data phases.
  task automatic rd2_chk(input logic [3:0] a, input logic [31:0] e1, input logic [31:0] e2);
    push_rd(a, e1); push_rd(a, e2);
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b0; bus.HADDR = {28'h0, a}; bus.HSIZE = 3'b010;
    @(posedge HCLK); #1;
    @(posedge HCLK); #1;
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
    @(posedge HCLK); #1;
  endtask

  task automatic push_pins(input logic chk_mosi, input logic [31:0] ss);
    pin_exp[pin_wr] = {chk_mosi, 1'b0, ss, 1'b0}; pin_wr = pin_wr + 1;
    @(posedge HCLK); #1;
  endtask

  task automatic do_reset();
    HRESET = 1'b1;
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
    @(posedge HCLK); #1;
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    model_reset();
  endtask

  // Start a transfer of d with NB=nb while the slave returns s; checks the boundary around completion.
  task automatic run_xfer(input logic [1:0] nb, input logic [31:0] d, input logic [31:0] s,
                          input logic [2:0] sz, input bit guard);
    int n, d0;
    logic [31:0] g, e1;
    n = 8 * (int'(nb) + 1) * DIV;
    if (m_nb != nb) begin
      xfer(1'b1, 4'h0, {24'h0, nb, 6'h00}, 3'b010);
      m_nb = nb;
    end
    for (int i = int'(nb); i >= 0; i--) begin
      mo_exp[mo_wr] = d[8*i +: 8]; mo_wr = mo_wr + 1;
      for (int k = 7; k >= 0; k--) begin
        miso_mem[mi_wr] = s[8*i + k]; mi_wr = mi_wr + 1;
      end
    end
    xfer(1'b1, 4'h8, d, sz);
    d0 = dcyc;
    m_tx = d; m_done = 1'b0;
    rd_chk(4'h0, stat(1'b1));
    if (guard) begin
      g = $urandom;
      xfer(1'b1, 4'h8, g, 3'b010);
      rd_chk(4'h8, m_tx);
    end
    while (cyc < d0 + n - 1) begin
      @(posedge HCLK); #1;
    end
    for (int i = int'(nb); i >= 0; i--) begin
      m_rx = {m_rx[23:0], s[8*i +: 8]};
      if (m_cnt < 4) m_cnt = m_cnt + 1;
    end
    e1 = stat(1'b1);
    m_done = 1'b1;
    rd2_chk(4'h0, e1, stat(1'b0));
  endtask

  initial begin
    logic [31:0] r;
    bus.HSEL = 1'b0; bus.HREADY = 1'b1; bus.HADDR = 32'h0; bus.HWRITE = 1'b0;
    bus.HSIZE = 3'b010; bus.HTRANS = 2'b00; bus.HWDATA = 32'h0;
    #1;
    do_reset();

    push_pins(1'b1, 32'hFFFF_FFFF);
    rd_chk(4'h0, 32'h0);
    rd_chk(4'h4, 32'hFFFF_FFFF);
    rd_chk(4'h8, 32'h0);
    rd_chk(4'hC, 32'h0);

    xfer(1'b1, 4'h0, 32'h0000_0040, 3'b010); m_nb = 2'd1;
    xfer(1'b1, 4'h4, 32'hFFFF_FFFE, 3'b010); m_ss = 32'hFFFF_FFFE;
    rd_chk(4'h0, 32'h0000_0040);
    rd_chk(4'h4, 32'hFFFF_FFFE);
    push_pins(1'b0, 32'hFFFF_FFFE);

    run_xfer(2'd1, 32'h0000_1108, 32'h0000_0102, 3'b001, 1'b0);
    rd_chk(4'h0, 32'h0000_0050);
    run_xfer(2'd1, $urandom, 32'h0000_0304, 3'b010, 1'b1);
    rd_chk(4'h0, 32'h0000_0051);
    rd_chk(4'hC, 32'h0102_0304);
    rd_chk(4'h0, 32'h0000_0040);
    rd_chk(4'hC, 32'h0102_0304);

    for (int it = 0; it < 6; it++) begin
      r = $urandom;
      xfer(1'b1, 4'h4, r, 3'b010); m_ss = r;
      push_pins(1'b0, m_ss);
      run_xfer(2'($urandom_range(0, 3)), $urandom, $urandom, 3'b010, 1'($urandom_range(0, 1)));
      rd_chk(4'h8, m_tx);
      if ($urandom_range(0, 1) == 1) rd_chk(4'hC, m_rx);
    end

    // Reset in the middle of a four-byte transfer.
    xfer(1'b1, 4'h0, 32'h0000_00C0, 3'b010); m_nb = 2'd3;
    r = $urandom;
    xfer(1'b1, 4'h8, r, 3'b010);
    repeat (3 * DIV) begin
      @(posedge HCLK); #1;
    end
    do_reset();
    push_pins(1'b1, 32'hFFFF_FFFF);
    rd_chk(4'h0, 32'h0);
    rd_chk(4'h8, 32'h0);
    rd_chk(4'hC, 32'h0);

    run_xfer(2'd0, $urandom, $urandom, 3'b000, 1'b1);
    rd_chk(4'hC, m_rx);
    rd_chk(4'h0, stat(1'b0));

    end_req = 1'b1;
  end
endmodule

// File: doc/ahb_spi.md
# ahb_spi

AHB-Lite slave implementing a byte-oriented SPI master with 32 software-controlled slave-select lines. Software writes 1–4 bytes through a data register, the block shifts them out MSB-first while capturing MISO into a 32-bit receive shift register, and reports completion through a status register. The Nexys4 display controller is attached as SPI slave 0 (`SPI_SS_o[0]`).

## Interface
- `SCLK_DIV`, default 32: HCLK cycles per SPI clock period; must be even, ≥2.
- `HCLK` in 1: single clock for all logic.
- `HRESET` in 1: synchronous, active-high reset.
- `HSEL` in 1: slave select.
- `HREADY` in 1: bus ready; the transfer is accepted only when high.
- `HADDR` in 32: address; only [3:2] are decoded.
- `HWRITE` in 1: write transfer.
- `HSIZE` in 3: transfer size; ignored, full 32-bit registers.
- `HTRANS` in 2: only bit 1 is used (NONSEQ/SEQ).
- `HWDATA` in 32: write data in the data phase.
- `HRDATA` out 32: read data.
- `HREADYOUT` out 1: constant 1, zero wait states.
- `SPI_MISO_i` in 1: serial data from slave.
- `SPI_MOSI_o` out 1: serial data to slave.
- `SPI_SS_o` out 32: slave selects, active low.
- `SPI_CLK_o` out 1: SPI clock, idle low.

## Operation
- Address phase: when `HSEL & HTRANS[1] & HREADY`, register addr[3:2] and HWRITE. Data phase acts on registered values.
- 0x0 CTRL/STAT: [7:6] NB, R/W, bytes per transfer = NB+1. [4] TX_DONE, RO. [1] BUSY, RO. [0] RX_FULL, RO. Other bits read 0.
- 0x4 SS: R/W; drives `SPI_SS_o` directly. Not touched by transfers.
- 0x8 TXDATA: write loads `HWDATA` and starts a transfer of NB+1 bytes from `TXDATA[8*(NB+1)-1:0]`. The highest valid byte goes first, each byte MSB-first. Ignored while BUSY. Reads return the last written value.
- 0xC RXDATA: RO. Each received byte shifts in: `rx <= {rx[23:0], byte}`. Reading it clears TX_DONE, RX_FULL and the received-byte counter in the data phase. It does not clear `rx`.
- Starting a transfer sets BUSY and clears TX_DONE.
- RX byte counter: incremented per completed byte, saturating at 4. RX_FULL = (count == 4). Bytes keep shifting into `rx` after saturation.
- SPI mode 0 (CPOL=0, CPHA=0):
  - MOSI is valid before each rising SCLK edge and changes only while SCLK is low.
  - MISO is sampled on the rising edge.
- FSM states:
  - IDLE: on a valid TXDATA write, go to LOW.
  - LOW: SCLK=0 for SCLK_DIV/2 cycles, then HIGH.
  - HIGH: SCLK=1 for SCLK_DIV/2 cycles. Then, if bits remain, go to LOW; otherwise go to IDLE and set TX_DONE.
- Simultaneous events:
  - An RXDATA read in the same cycle a byte completes: the clear wins for flags, and the count becomes 1.
  - Transfer finish in the same cycle as an RXDATA read: TX_DONE ends set.

## Timing
- Reset values:
  - `HRDATA`=0, `HREADYOUT`=1.
  - `SPI_SS_o`=0xFFFF_FFFF, `SPI_CLK_o`=0, `SPI_MOSI_o`=0.
  - CTRL=0, TXDATA=0, rx=0, count=0, FSM=IDLE.
- Reset mid-transfer aborts immediately to the reset state.
- `HRDATA` is valid in the data phase: combinational from the registered address, reflecting register state at that cycle.
- Transfer start: the FSM enters LOW on the cycle after the TXDATA data phase. The first MOSI bit is driven in that same cycle.
- Per bit: SCLK_DIV HCLK cycles.
  - MISO is captured in the cycle SCLK goes high.
  - The next MOSI bit is presented in the cycle SCLK goes low.
- The full transfer takes 8·(NB+1)·SCLK_DIV cycles. BUSY clears and TX_DONE sets in the cycle after the last HIGH phase, with SCLK back at 0.

## Test plan
- Reset:
  - Stimulus: assert HRESET for 2 cycles.
  - Required: `SPI_SS_o`=0xFFFFFFFF, `SPI_CLK_o`=0, and a read of 0x0 returns 0.
- Register R/W:
  - Stimulus: write 0x0=0x40, 0x4=0xFFFFFFFE.
  - Required: reads return 0x40 and 0xFFFFFFFE, and `SPI_SS_o`=0xFFFFFFFE.
- Two-byte TX:
  - Stimulus: NB=1, write 0x8=0x1108 (HSIZE=HALF).
  - Required: MOSI carries 0x11 then 0x08 MSB-first over 16 rising SCLK edges. BUSY is 1 during the transfer. TX_DONE=1 afterwards and STAT reads 0x50.
- RX capture:
  - Stimulus: slave drives 0x01,0x02,0x03,0x04 MSB-first (changing after each rising edge); run two 2-byte transfers.
  - Required: RXDATA=0x01020304 and RX_FULL=1 after the second transfer.
- Flag clear:
  - Stimulus: read 0xC.
  - Required: TX_DONE=0, RX_FULL=0, and RXDATA still 0x01020304.
- Busy guard:
  - Stimulus: write 0x8 mid-transfer.
  - Required: the write is ignored, the bit stream is unchanged, and TXDATA keeps its old value.
